// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 8 x 16-bit register file.
// Two writeback sources (A = ALU, B = load/memory) compete for the single
// write port using round-robin arbitration. The winner is registered into an
// output stage that drives the register file's active-low write strobe.
//
// last_grant | meaning
// -----------+---------------------------------------------------------
// LAST_A     | A won the most recent grant; B wins the next conflict
// LAST_B     | B won the most recent grant (reset); A wins next conflict
module regfile_write_arbiter #(
    parameter int DataWidth  = 16,
    parameter int SelectSize = 3,
    parameter int CntWidth   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      stall_i,
    input  logic                      a_req_i,
    input  logic [SelectSize-1:0]     a_dst_i,
    input  logic [DataWidth-1:0]      a_data_i,
    output logic                      a_ready_o,
    input  logic                      b_req_i,
    input  logic [SelectSize-1:0]     b_dst_i,
    input  logic [DataWidth-1:0]      b_data_i,
    output logic                      b_ready_o,
    output logic                      reg_we_no,
    output logic [SelectSize-1:0]     reg_dst_o,
    output logic [DataWidth-1:0]      data_o,
    output logic [2**SelectSize-1:0]  busy_o,
    output logic [CntWidth-1:0]       conflicts_o
);

    localparam logic [0:0] LAST_A = 1'b0;
    localparam logic [0:0] LAST_B = 1'b1;

    logic [0:0]            last_grant;
    logic                  grant_a;
    logic                  grant_b;
    logic                  grant_any;
    logic                  conflict;
    logic [SelectSize-1:0] win_dst;
    logic [DataWidth-1:0]  win_data;

    // Round-robin grant; nothing is granted while in reset or stalled.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_ni && !stall_i) begin
            if (a_req_i && b_req_i) begin
                if (last_grant == LAST_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else begin
                grant_a = a_req_i;
                grant_b = b_req_i;
            end
        end
    end

    assign grant_any = grant_a | grant_b;
    assign win_dst   = grant_a ? a_dst_i  : b_dst_i;
    assign win_data  = grant_a ? a_data_i : b_data_i;
    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;
    assign conflict  = a_req_i && b_req_i && !stall_i;

    // Output stage: a grant becomes a one-cycle write strobe on the next edge;
    // select and data hold their last values between writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_we_no <= 1'b1;
            reg_dst_o <= '0;
            data_o    <= '0;
        end else if (grant_any) begin
            reg_we_no <= 1'b0;
            reg_dst_o <= win_dst;
            data_o    <= win_data;
        end else begin
            reg_we_no <= 1'b1;
        end
    end

    // Remember the most recent winner; stalls and idle cycles leave it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= LAST_B;
        end else if (grant_a) begin
            last_grant <= LAST_A;
        end else if (grant_b) begin
            last_grant <= LAST_B;
        end
    end

    // Saturating count of unstalled cycles where both sources requested.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflicts_o <= '0;
        end else if (conflict && (conflicts_o != '1)) begin
            conflicts_o <= conflicts_o + 1'b1;
        end
    end

    // One-hot mask of the register being written this cycle.
    always_comb begin
        busy_o = '0;
        if (!reg_we_no) begin
            busy_o[reg_dst_o] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        a_req;
    logic [2:0]  a_dst;
    logic [15:0] a_data;
    logic        b_req;
    logic [2:0]  b_dst;
    logic [15:0] b_data;

    logic        a_ready, b_ready, reg_we_no;
    logic [2:0]  reg_dst;
    logic [15:0] data_out;
    logic [7:0]  busy;
    logic [7:0]  conflicts;

    logic        s_a_ready, s_b_ready, s_we_no;
    logic [2:0]  s_dst;
    logic [15:0] s_data;
    logic [7:0]  s_busy;
    logic [1:0]  s_conflicts;

    int total = 0;
    int bad = 0;

    regfile_write_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
        .a_req_i(a_req), .a_dst_i(a_dst), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_req_i(b_req), .b_dst_i(b_dst), .b_data_i(b_data), .b_ready_o(b_ready),
        .reg_we_no(reg_we_no), .reg_dst_o(reg_dst), .data_o(data_out),
        .busy_o(busy), .conflicts_o(conflicts)
    );

    regfile_write_arbiter #(.CntWidth(2)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
        .a_req_i(a_req), .a_dst_i(a_dst), .a_data_i(a_data), .a_ready_o(s_a_ready),
        .b_req_i(b_req), .b_dst_i(b_dst), .b_data_i(b_data), .b_ready_o(s_b_ready),
        .reg_we_no(s_we_no), .reg_dst_o(s_dst), .data_o(s_data),
        .busy_o(s_busy), .conflicts_o(s_conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [2:0]  dst;
        logic [15:0] data;
        int          cnt;
        int          cnt2;
    } exp_t;

    exp_t        q[$];
    logic [15:0] tb_rf [8];
    logic [15:0] ref_rf [8];
    int          m_last;      // 1 = A, 2 = B
    int          m_cnt;
    int          m_cnt2;
    bit          m_ga;
    bit          m_gb;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Register file fed by the DUT's write port.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) tb_rf[i] <= '0;
        end else if (!reg_we_no) begin
            tb_rf[reg_dst] <= data_out;
        end
    end

    // Reference model: decides the winner for the upcoming edge from the
    // request rules and pushes the write it expects to see next cycle.
    initial begin
        m_last = 2; m_cnt = 0; m_cnt2 = 0; m_ga = 0; m_gb = 0;
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        forever begin
            int   win;
            exp_t e;
            @(negedge clk);
            #1;
            if (!rst_n) begin
                m_last = 2; m_cnt = 0; m_cnt2 = 0; m_ga = 0; m_gb = 0;
                for (int i = 0; i < 8; i++) ref_rf[i] = '0;
                q.delete();
                continue;
            end
            win = 0;
            if (!stall) begin
                if (a_req && b_req) win = (m_last == 2) ? 1 : 2;
                else if (a_req)     win = 1;
                else if (b_req)     win = 2;
            end
            check("a_ready", a_ready, 32'(win == 1));
            check("b_ready", b_ready, 32'(win == 2));
            e.we   = (win != 0);
            e.dst  = (win == 1) ? a_dst  : b_dst;
            e.data = (win == 1) ? a_data : b_data;
            if (e.we) begin
                ref_rf[e.dst] = e.data;
                m_last = win;
            end
            if (a_req && b_req && !stall) begin
                m_cnt  = (m_cnt  >= 255) ? 255 : m_cnt + 1;
                m_cnt2 = (m_cnt2 >= 3)   ? 3   : m_cnt2 + 1;
            end
            e.cnt  = m_cnt;
            e.cnt2 = m_cnt2;
            q.push_back(e);
            m_ga = (win == 1);
            m_gb = (win == 2);
        end
    end

    // Monitor: compares the registered write port against the scoreboard.
    initial begin
        forever begin
            exp_t e;
            logic [7:0] eb;
            @(negedge clk);
            if (!rst_n) begin
                check("rst_a_ready", a_ready, 0);
                check("rst_b_ready", b_ready, 0);
                check("rst_we_n", reg_we_no, 1);
                check("rst_busy", busy, 0);
                check("rst_conflicts", conflicts, 0);
                q.delete();
            end else if (q.size() > 0) begin
                e = q.pop_front();
                check("we_n", reg_we_no, 32'(!e.we));
                if (e.we) begin
                    check("dst", reg_dst, e.dst);
                    check("data", data_out, e.data);
                end
                eb = e.we ? (8'd1 << e.dst) : 8'd0;
                check("busy", busy, eb);
                check("conflicts", conflicts, e.cnt);
                check("conflicts_small", s_conflicts, e.cnt2);
            end else begin
                check("idle_we_n", reg_we_no, 1);
                check("idle_busy", busy, 0);
                check("idle_conflicts", conflicts, m_cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (m_ga) a_req = 1'b0;
        if (m_gb) b_req = 1'b0;
    endtask

    task automatic drain();
        stall = 1'b0;
        for (int k = 0; k < 20 && (a_req || b_req); k++) step();
        if (a_req || b_req) check("drain_timeout", 1, 0);
        step();
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_a(input logic [2:0] d, input logic [15:0] v);
        a_req = 1'b1; a_dst = d; a_data = v;
    endtask

    task automatic set_b(input logic [2:0] d, input logic [15:0] v);
        b_req = 1'b1; b_dst = d; b_data = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        // Requests asserted during reset must not be granted.
        set_a(3'd1, 16'h5555);
        set_b(3'd2, 16'h6666);
        repeat (2) @(posedge clk);
        #1;
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b1;
        step();

        // Single A write to R0.
        set_a(3'd0, 16'h00A0);
        step();
        step();
        step();
        check("r0_value", tb_rf[0], 16'h00A0);

        // Conflict right after reset: A first, then B.
        do_reset();
        set_a(3'd1, 16'h000A);
        set_b(3'd2, 16'h1234);
        drain();
        check("first_conflict_cnt", conflicts, 1);
        check("r1_value", tb_rf[1], 16'h000A);
        check("r2_value", tb_rf[2], 16'h1234);

        // Same destination with last grant = A: B writes first, A last.
        set_a(3'd4, 16'h4444);
        drain();
        set_a(3'd3, 16'h1111);
        set_b(3'd3, 16'h2222);
        drain();
        check("r3_same_dst", tb_rf[3], 16'h1111);

        // Stall with both requesting, then release.
        stall = 1'b1;
        set_a(3'd6, 16'h6A6A);
        set_b(3'd7, 16'h7B7B);
        repeat (3) step();
        check("stall_holds_a", a_req, 1);
        drain();

        // Continuous conflicts to saturate both counters.
        for (int i = 0; i < 300; i++) begin
            if (!a_req) set_a(3'($urandom_range(0, 7)), 16'($urandom));
            if (!b_req) set_b(3'($urandom_range(0, 7)), 16'($urandom));
            step();
        end
        drain();
        check("sat_conflicts", conflicts, 255);
        check("sat_conflicts_small", s_conflicts, 3);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            stall = ($urandom_range(0, 7) == 0);
            if (!a_req && $urandom_range(0, 99) < 60) set_a(3'($urandom_range(0, 7)), 16'($urandom));
            if (!b_req && $urandom_range(0, 99) < 60) set_b(3'($urandom_range(0, 7)), 16'($urandom));
            step();
        end
        drain();
        for (int i = 0; i < 8; i++) check($sformatf("rf_%0d", i), tb_rf[i], ref_rf[i]);

        // Asynchronous reset while a write strobe is active.
        set_a(3'd5, 16'hBEEF);
        step();
        #2;
        check("we_before_rst", reg_we_no, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_we_n", reg_we_no, 1);
        check("async_rst_busy", busy, 0);
        do_reset();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
